// File: rtl/riscv_defs.sv
// Shared RV32I decode enumerations and opcode constants.
// RISCV_DECODE_RV32M_EN adds the RV32M ALU operations to exec_fun_e.
package riscv_defs;

   typedef enum logic [4:0] {
      ALU_X    = 5'd0,
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND,
      ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
`ifdef RISCV_DECODE_RV32M_EN
      ,
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
`endif
   } exec_fun_e;

   typedef enum logic [1:0] {OP1_X = 2'd0, OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;
   typedef enum logic [2:0] {OP2_X = 3'd0, OP2_RS2, OP2_IMI, OP2_IMS, OP2_IMB, OP2_IMU, OP2_IMJ} op2_sel_e;
   typedef enum logic [1:0] {WB_X = 2'd0, WB_ALU, WB_MEM, WB_PC} wb_sel_e;
   typedef enum logic       {RF_X = 1'b0, RF_WRITE} rf_wen_e;
   typedef enum logic [1:0] {MEM_X = 2'd0, MEM_RD, MEM_WR} mem_wen_e;
   typedef enum logic [2:0] {PC_X = 3'd0, PC_4, PC_BR, PC_JAL, PC_ALU} pc_sel_e;
   typedef enum logic [1:0] {MSK_X = 2'd0, MSK_B, MSK_H, MSK_W} mask_sel_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/riscv_decode_stage_if.sv
// Fetch-side and execute-side handshake plus decoded bundle of the decode stage.
// slave = the decode stage itself; master = the fetch/execute environment around it.
interface riscv_decode_stage_if
   import riscv_defs::*;
#(
   parameter int WORD_LENGTH = 32,
   parameter int PC_WIDTH    = 32
) ();

   logic                   in_valid;
   logic                   in_ready;
   logic [WORD_LENGTH-1:0] inst_i;
   logic [PC_WIDTH-1:0]    pc_i;

   logic                   out_valid;
   logic                   out_ready;
   logic [PC_WIDTH-1:0]    pc_o;
   logic [4:0]             rd_o;
   logic [4:0]             rs1_o;
   logic [4:0]             rs2_o;
   logic [WORD_LENGTH-1:0] imm_o;
   exec_fun_e              exec_fun;
   op1_sel_e               op1_sel;
   op2_sel_e               op2_sel;
   wb_sel_e                wb_sel;
   rf_wen_e                rf_wen;
   mem_wen_e               mem_wen;
   pc_sel_e                pc_sel;
   mask_sel_e              rs2_mask_sel;
   logic                   mem_sext_o;
   logic                   invalid_o;

   modport slave (
      input  in_valid, inst_i, pc_i, out_ready,
      output in_ready, out_valid, pc_o, rd_o, rs1_o, rs2_o, imm_o,
             exec_fun, op1_sel, op2_sel, wb_sel, rf_wen, mem_wen, pc_sel,
             rs2_mask_sel, mem_sext_o, invalid_o
   );

   modport master (
      output in_valid, inst_i, pc_i, out_ready,
      input  in_ready, out_valid, pc_o, rd_o, rs1_o, rs2_o, imm_o,
             exec_fun, op1_sel, op2_sel, wb_sel, rf_wen, mem_wen, pc_sel,
             rs2_mask_sel, mem_sext_o, invalid_o
   );

endinterface

// File: rtl/riscv_decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer and saturating illegal counter.
// Optional RV32M decode is enabled by defining RISCV_DECODE_RV32M_EN.
module riscv_decode_stage
   import riscv_defs::*;
#(
   parameter int WORD_LENGTH = 32,
   parameter int PC_WIDTH    = 32,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   riscv_decode_stage_if.slave   bus,
   output logic [CNT_WIDTH-1:0]  illegal_cnt,
   output logic [1:0]            dbg_state_o
);

   if (WORD_LENGTH != 32) begin : g_bad_width
      $error("riscv_decode_stage: WORD_LENGTH must be 32");
   end

   // Handshake: a transfer happens on a cycle where valid and ready are both high;
   // valid never depends on ready, and a presented bundle holds until it transfers.
   typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2} state_e;

   typedef struct packed {
      logic [PC_WIDTH-1:0]    pc;
      logic [4:0]             rd;
      logic [4:0]             rs1;
      logic [4:0]             rs2;
      logic [WORD_LENGTH-1:0] imm;
      exec_fun_e              exec_fun;
      op1_sel_e               op1;
      op2_sel_e               op2;
      wb_sel_e                wb;
      rf_wen_e                rf_wen;
      mem_wen_e               mem_wen;
      pc_sel_e                pc_sel;
      mask_sel_e              mask;
      logic                   mem_sext;
      logic                   invalid;
   } bundle_t;

   state_e               state_q, state_d;
   logic                 in_ready_q, in_ready_d;
   bundle_t              out_q, out_d;
   bundle_t              skid_q, skid_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   bundle_t              dec;
   logic                 in_fire, out_fire;

   logic [WORD_LENGTH-1:0] inst;
   logic [6:0]             opcode, funct7;
   logic [2:0]             funct3;
   logic [4:0]             rd_f, rs1_f, rs2_f;
   logic [WORD_LENGTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign inst   = bus.inst_i;
   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];
   assign rd_f   = inst[11:7];
   assign rs1_f  = inst[19:15];
   assign rs2_f  = inst[24:20];
   assign imm_i  = {{20{inst[31]}}, inst[31:20]};
   assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u  = {inst[31:12], 12'b0};
   assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   function automatic exec_fun_e alu_decode(input logic [2:0] f3, input logic alt);
      exec_fun_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   always_comb begin
      logic legal;
      legal   = 1'b1;
      dec     = '0;
      dec.pc  = bus.pc_i;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            dec.rd = rd_f; dec.imm = imm_u; dec.exec_fun = ALU_ADD;
            dec.op1 = (opcode == OPC_LUI) ? OP1_ZERO : OP1_PC;
            dec.op2 = OP2_IMU; dec.wb = WB_ALU; dec.rf_wen = RF_WRITE; dec.pc_sel = PC_4;
         end
         OPC_JAL: begin
            dec.rd = rd_f; dec.imm = imm_j; dec.exec_fun = ALU_ADD; dec.op1 = OP1_PC;
            dec.op2 = OP2_IMJ; dec.wb = WB_PC; dec.rf_wen = RF_WRITE; dec.pc_sel = PC_JAL;
         end
         OPC_JALR: begin
            legal = (funct3 == 3'b000);
            dec.rd = rd_f; dec.rs1 = rs1_f; dec.imm = imm_i; dec.exec_fun = ALU_ADD;
            dec.op1 = OP1_RS1; dec.op2 = OP2_IMI; dec.wb = WB_PC; dec.rf_wen = RF_WRITE;
            dec.pc_sel = PC_ALU;
         end
         OPC_BRANCH: begin
            dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.imm = imm_b; dec.op1 = OP1_RS1;
            dec.op2 = OP2_RS2; dec.pc_sel = PC_BR;
            case (funct3)
               3'b000:  dec.exec_fun = ALU_BEQ;
               3'b001:  dec.exec_fun = ALU_BNE;
               3'b100:  dec.exec_fun = ALU_BLT;
               3'b101:  dec.exec_fun = ALU_BGE;
               3'b110:  dec.exec_fun = ALU_BLTU;
               3'b111:  dec.exec_fun = ALU_BGEU;
               default: legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
            dec.rd = rd_f; dec.rs1 = rs1_f; dec.imm = imm_i; dec.exec_fun = ALU_ADD;
            dec.op1 = OP1_RS1; dec.op2 = OP2_IMI; dec.wb = WB_MEM; dec.rf_wen = RF_WRITE;
            dec.mem_wen = MEM_RD; dec.pc_sel = PC_4;
            dec.mask = (funct3[1:0] == 2'b00) ? MSK_B : (funct3[1:0] == 2'b01) ? MSK_H : MSK_W;
            dec.mem_sext = (funct3 == 3'b000) || (funct3 == 3'b001);
         end
         OPC_STORE: begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.imm = imm_s; dec.exec_fun = ALU_ADD;
            dec.op1 = OP1_RS1; dec.op2 = OP2_IMS; dec.mem_wen = MEM_WR; dec.pc_sel = PC_4;
            dec.mask = (funct3[1:0] == 2'b00) ? MSK_B : (funct3[1:0] == 2'b01) ? MSK_H : MSK_W;
         end
         OPC_OPIMM: begin
            // Shift-immediates reuse the funct7 slot; only SRAI may set the alt bit.
            if (funct3 == 3'b001) legal = (funct7 == 7'b0000000);
            if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            dec.rd = rd_f; dec.rs1 = rs1_f; dec.imm = imm_i;
            dec.exec_fun = alu_decode(funct3, (funct3 == 3'b101) && funct7[5]);
            dec.op1 = OP1_RS1; dec.op2 = OP2_IMI; dec.wb = WB_ALU; dec.rf_wen = RF_WRITE;
            dec.pc_sel = PC_4;
         end
         OPC_OP: begin
            dec.rd = rd_f; dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.op1 = OP1_RS1;
            dec.op2 = OP2_RS2; dec.wb = WB_ALU; dec.rf_wen = RF_WRITE; dec.pc_sel = PC_4;
            if (funct7 == 7'b0000000) begin
               dec.exec_fun = alu_decode(funct3, 1'b0);
            end else if (funct7 == 7'b0100000) begin
               legal = (funct3 == 3'b000) || (funct3 == 3'b101);
               dec.exec_fun = alu_decode(funct3, 1'b1);
`ifdef RISCV_DECODE_RV32M_EN
            end else if (funct7 == 7'b0000001) begin
               case (funct3)
                  3'b000:  dec.exec_fun = ALU_MUL;
                  3'b001:  dec.exec_fun = ALU_MULH;
                  3'b010:  dec.exec_fun = ALU_MULHSU;
                  3'b011:  dec.exec_fun = ALU_MULHU;
                  3'b100:  dec.exec_fun = ALU_DIV;
                  3'b101:  dec.exec_fun = ALU_DIVU;
                  3'b110:  dec.exec_fun = ALU_REM;
                  default: dec.exec_fun = ALU_REMU;
               endcase
`endif
            end else begin
               legal = 1'b0;
            end
         end
         OPC_FENCE: begin
            legal = (funct3 == 3'b000);
            dec.pc_sel = PC_4;
         end
         OPC_SYSTEM: begin
            // EBREAK is a recognised no-op that is still reported as illegal for now.
            legal = (inst == 32'h0000_0073) || (inst == 32'h0010_0073);
            dec.pc_sel  = PC_4;
            dec.invalid = (inst == 32'h0010_0073);
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec         = '0;
         dec.pc      = bus.pc_i;
         dec.invalid = 1'b1;
      end else if (dec.rd == 5'd0) begin
         dec.rf_wen = RF_X;
      end
   end

   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      skid_d   = skid_q;
      cnt_d    = cnt_q;
      in_fire  = bus.in_valid && in_ready_q;
      out_fire = (state_q != S_EMPTY) && bus.out_ready;
      case (state_q)
         S_EMPTY: begin
            if (in_fire) begin
               state_d = S_ONE;
               out_d   = dec;
            end
         end
         S_ONE: begin
            if (in_fire && out_fire) begin
               out_d = dec;
            end else if (in_fire) begin
               state_d = S_FULL;
               skid_d  = dec;
            end else if (out_fire) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            if (out_fire) begin
               state_d = S_ONE;
               out_d   = skid_q;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      if (out_fire && out_q.invalid && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      if (flush) begin
         state_d = S_EMPTY;
         cnt_d   = cnt_q;
      end
      in_ready_d = (state_d != S_FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_EMPTY;
         in_ready_q <= 1'b1;
         out_q      <= '0;
         skid_q     <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = (state_q != S_EMPTY);
   assign bus.pc_o         = out_q.pc;
   assign bus.rd_o         = out_q.rd;
   assign bus.rs1_o        = out_q.rs1;
   assign bus.rs2_o        = out_q.rs2;
   assign bus.imm_o        = out_q.imm;
   assign bus.exec_fun     = out_q.exec_fun;
   assign bus.op1_sel      = out_q.op1;
   assign bus.op2_sel      = out_q.op2;
   assign bus.wb_sel       = out_q.wb;
   assign bus.rf_wen       = out_q.rf_wen;
   assign bus.mem_wen      = out_q.mem_wen;
   assign bus.pc_sel       = out_q.pc_sel;
   assign bus.rs2_mask_sel = out_q.mask;
   assign bus.mem_sext_o   = out_q.mem_sext;
   assign bus.invalid_o    = out_q.invalid;
   assign illegal_cnt      = cnt_q;
   assign dbg_state_o      = state_q;

endmodule
